seq_wide_adder: RTL and testbench

SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

---
 rtl/seq_wide_adder.sv | 156 +++++++++++++++
 tb/tb_seq_wide_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder.sv
// Sequential wide adder: adds two W-bit operands one N-bit slice per clock,
// rippling the carry between slices through a register. Reports the carry
// out of the top slice and two's-complement overflow of the full-width add.
module seq_wide_adder #(
    parameter int N  = 4,
    parameter int K  = 2,
    localparam int W  = N * K,
    localparam int SW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          cin,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  y,
    output logic          cout,
    output logic          ovf,
    output logic [SW-1:0] slice_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_IDX = SW'(K - 1);

    // N-bit ripple-carry add. Result packs {carry into MSB, carry out, sum}
    // so the caller can derive overflow from the top two carries.
    function automatic logic [N+1:0] ripple_add(input logic [N-1:0] x,
                                                input logic [N-1:0] z,
                                                input logic         ci);
        logic [N:0]   c;
        logic [N-1:0] s;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = x[i] ^ z[i] ^ c[i];
            c[i+1] = (x[i] & z[i]) | (c[i] & (x[i] ^ z[i]));
        end
        return {c[N-1], c[N], s};
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    y_q, y_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [SW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N+1:0]    sum_s;
    int              base_s;

    // Slice datapath: add the currently selected slice with the running carry.
    always_comb begin
        base_s = int'(idx_q) * N;
        sum_s  = ripple_add(a_q[base_s +: N], b_q[base_s +: N], carry_q);
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    y_d     = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_RUN: begin
                y_d[base_s +: N] = sum_s[N-1:0];
                carry_d          = sum_s[N];
                if (idx_q == LAST_IDX) begin
                    cout_d  = sum_s[N];
                    ovf_d   = sum_s[N+1] ^ sum_s[N];
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + SW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; async reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign slice_idx = idx_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Self-checking bench for seq_wide_adder (N=4, K=2): directed corner cases
// plus randomized operands checked against a plain-arithmetic reference.
module tb_seq_wide_adder;

    localparam int N = 4;
    localparam int K = 2;
    localparam int W = N * K;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;
    logic [0:0]   slice_idx;

    int tests_run;
    int tests_failed;

    seq_wide_adder #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .cout      (cout),
        .ovf       (ovf),
        .slice_idx (slice_idx)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: full-width arithmetic sum and sign-based overflow.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] z, input logic ci);
        logic [W:0]   full;
        logic         ov;
        full = {1'b0, x} + {1'b0, z} + {{W{1'b0}}, ci};
        ov   = (x[W-1] == z[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full};
    endfunction

    // Launch one add and check every cycle through DONE and the hold cycle.
    task automatic do_add(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        logic [W+1:0] r;
        logic [W:0]   lo;
        r  = ref_add(xa, xb, xc);
        lo = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        @(negedge clk);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check_val({tag, ".busy0"}, 32'(busy), 32'd1);
        check_val({tag, ".idx0"},  32'(slice_idx), 32'd0);
        check_val({tag, ".done0"}, 32'(done), 32'd0);
        @(negedge clk);
        check_val({tag, ".busy1"}, 32'(busy), 32'd1);
        check_val({tag, ".idx1"},  32'(slice_idx), 32'd1);
        check_val({tag, ".ylo"},   32'(y[N-1:0]), 32'(lo[N-1:0]));
        @(negedge clk);
        check_val({tag, ".done"},  32'(done), 32'd1);
        check_val({tag, ".busy2"}, 32'(busy), 32'd0);
        check_val({tag, ".y"},     32'(y), 32'(r[W-1:0]));
        check_val({tag, ".cout"},  32'(cout), 32'(r[W]));
        check_val({tag, ".ovf"},   32'(ovf), 32'(r[W+1]));
        check_val({tag, ".idx2"},  32'(slice_idx), 32'd0);
        @(negedge clk);
        check_val({tag, ".done_off"}, 32'(done), 32'd0);
        check_val({tag, ".y_hold"},   32'(y), 32'(r[W-1:0]));
        check_val({tag, ".c_hold"},   32'(cout), 32'(r[W]));
    endtask

    // Check all outputs are in their reset values.
    task automatic check_zero(input string tag);
        check_val({tag, ".busy"}, 32'(busy), 32'd0);
        check_val({tag, ".done"}, 32'(done), 32'd0);
        check_val({tag, ".y"},    32'(y), 32'd0);
        check_val({tag, ".cout"}, 32'(cout), 32'd0);
        check_val({tag, ".ovf"},  32'(ovf), 32'd0);
        check_val({tag, ".idx"},  32'(slice_idx), 32'd0);
    endtask

    // Main stimulus sequence.
    initial begin
        logic [W+1:0] r1;
        logic [W+1:0] r2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Directed corner cases.
        do_add("v030", 8'h77, 8'h5B, 1'b0);
        do_add("v031", 8'h7F, 8'hB1, 1'b1);
        do_add("v032a", 8'hFF, 8'h00, 1'b1);
        do_add("v032b", 8'h80, 8'h80, 1'b0);

        // Start held high with operands changing during RUN.
        r1 = ref_add(8'h12, 8'h34, 1'b0);
        r2 = ref_add(8'hC3, 8'h9A, 1'b1);
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        a = 8'hC3; b = 8'h9A; cin = 1'b1;
        @(negedge clk);
        check_val("hold.done1", 32'(done), 32'd1);
        check_val("hold.y1",    32'(y), 32'(r1[W-1:0]));
        @(negedge clk);
        check_val("hold.no_b2b", 32'(done), 32'd0);
        check_val("hold.idle",   32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_val("hold.reaccept", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check_val("hold.done2", 32'(done), 32'd1);
        check_val("hold.y2",    32'(y), 32'(r2[W-1:0]));
        check_val("hold.c2",    32'(cout), 32'(r2[W]));

        // Reset pulsed between the two RUN edges.
        @(negedge clk);
        a = 8'h77; b = 8'h5B; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        check_val("midrst.done_a", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst.done_b", 32'(done), 32'd0);
        check_val("midrst.idle",   32'(busy), 32'd0);
        @(negedge clk);
        check_val("midrst.done_c", 32'(done), 32'd0);
        do_add("v034", 8'h01, 8'h01, 1'b0);

        // Randomized regression.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_add("rand", ra, rb, rc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
